// File: rtl/uart_pkg.sv
// Shared UART constants, FIFO sizing helper and FIFO operation encoding.
package uart_pkg;

    localparam int DBIT_DEFAULT   = 8;
    localparam int SB_TICK        = 16;
    localparam int ADDR_W_DEFAULT = 4;
    localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

    // Bit order is {push, pop} so the controller can cast its qualifiers directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_ctrl.sv
// Pointer, occupancy and sticky overrun bookkeeping for the UART receive FIFO.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_overrun,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] w_ptr,
    output logic [ADDR_W-1:0] r_ptr,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    fifo_op_e op;
    logic     drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A full FIFO still accepts a write when the same edge frees the head slot.
    assign rd_en = rd & ~empty;
    assign wr_en = wr & (~full | rd_en);
    assign drop  = wr & ~wr_en;
    assign op    = fifo_op_e'({wr_en, rd_en});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en)
                w_ptr <= w_ptr + ADDR_W'(1);
            if (rd_en)
                r_ptr <= r_ptr + ADDR_W'(1);

            case (op)
                OP_PUSH: count <= count + (ADDR_W+1)'(1);
                OP_POP:  count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase

            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures rx_done_tick characters into a FWFT circular FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int MEM_DEPTH = fifo_depth(ADDR_W);

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [DBIT-1:0]   mem [MEM_DEPTH];

    uart_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .rd          (rd),
        .clr_overrun (clr_overrun),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .w_ptr       (w_ptr),
        .r_ptr       (r_ptr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun)
    );

    // Storage is deliberately left unreset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[w_ptr] <= w_data;
    end

    assign r_data = empty ? '0 : mem[r_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = '0;
    logic       rd = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_q[$];
    logic       model_ovr = 1'b0;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".empty"},   32'(empty),   32'(model_q.size() == 0));
        check({tag, ".full"},    32'(full),    32'(model_q.size() == DEPTH));
        check({tag, ".count"},   32'(count),   32'(model_q.size()));
        check({tag, ".overrun"}, 32'(overrun), 32'(model_ovr));
        check({tag, ".r_data"},  32'(r_data),  (model_q.size() == 0) ? 32'h0 : 32'(model_q[0]));
    endtask

    // Reference behaviour: a queue of stored characters plus a sticky flag.
    task automatic model_apply(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit do_pop;
        bit do_push;
        do_pop  = r && (model_q.size() > 0);
        do_push = w && ((model_q.size() < DEPTH) || do_pop);
        if (c) model_ovr = 1'b0;
        if (w && !do_push) model_ovr = 1'b1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
    endtask

    task automatic cyc(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic c);
        wr = w; w_data = d; rd = r; clr_overrun = c;
        @(posedge clk);
        model_apply(w, d, r, c);
        #1;
        wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovr = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #3;
        async_reset("reset");

        // single character round trip
        cyc("push55", 1'b1, 8'h55, 1'b0, 1'b0);
        check("push55.rdata_lit", 32'(r_data), 32'h55);
        cyc("pop55", 1'b0, 8'h00, 1'b1, 1'b0);
        check("pop55.rdata_lit", 32'(r_data), 32'h00);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill.count_lit", 32'(count), 32'd16);
        cyc("drop_aa", 1'b1, 8'hAA, 1'b0, 1'b0);
        check("drop_aa.ovr_lit", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("drain.head_lit", 32'(r_data), 32'(i));
            cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // pointer wrap
        for (int i = 0; i < 10; i++) cyc("wrap_push10", 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("wrap_pop10", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc("wrap_push12", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            check("wrap.head_lit", 32'(r_data), 32'(8'h20 + i));
            cyc("wrap_pop12", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("wrap.empty_lit", 32'(empty), 32'd1);

        // simultaneous push/pop while full
        for (int i = 0; i < 16; i++) cyc("full_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cyc("full_both", 1'b1, 8'h77, 1'b1, 1'b0);
        check("full_both.count_lit", 32'(count), 32'd16);
        check("full_both.ovr_lit", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) cyc("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // simultaneous push/pop while empty, then rd on empty
        cyc("empty_both", 1'b1, 8'h3C, 1'b1, 1'b0);
        check("empty_both.rdata_lit", 32'(r_data), 32'h3C);
        cyc("pop3c", 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // overrun set-wins, then clear
        for (int i = 0; i < 16; i++) cyc("ovr_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cyc("ovr_set", 1'b1, 8'hEE, 1'b0, 1'b0);
        cyc("ovr_set_and_clr", 1'b1, 8'hEF, 1'b0, 1'b1);
        check("ovr_set_and_clr.lit", 32'(overrun), 32'd1);
        cyc("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovr_clr.lit", 32'(overrun), 32'd0);

        // reset mid-burst with five entries held
        for (int i = 0; i < 11; i++) cyc("to_five", 1'b0, 8'h00, 1'b1, 1'b0);
        check("to_five.count_lit", 32'(count), 32'd5);
        async_reset("midreset");
        cyc("post_reset", 1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic, phases biased toward filling and draining
        for (int n = 0; n < 3000; n++) begin
            int bias;
            bias = ((n / 300) % 2 == 0) ? 75 : 30;
            cyc("rand",
                ($urandom_range(99) < bias) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(99) < (105 - bias)) ? 1'b1 : 1'b0,
                ($urandom_range(15) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each completed character on the receiver's one-cycle done strobe and holds it in a circular FIFO.
- Presents the oldest character to the host/bus side in first-word-fall-through (FWFT) form.
- Flags characters lost when the buffer is full with a sticky overrun bit.

Parameters:
- DBIT, 8, character width in bits; matches the receiver data width.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W entries (16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  write strobe, connected to receiver rx_done_tick; one cycle per character.
- w_data  in  DBIT  character from receiver rx_dout; sampled when wr=1.
- rd  in  1  pop request from consumer; pops the head entry on the same clock edge.
- r_data  out  DBIT  head entry (FWFT); forced to 0 while empty.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds 2**ADDR_W entries.
- count  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
- overrun  out  1  sticky; a write was dropped because the FIFO was full.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, reset_n=0), effective immediately:
  - w_ptr=0, r_ptr=0, count=0.
  - empty=1, full=0, overrun=0, r_data=0.
  - Storage array is not reset.
- Reset mid-operation discards all contents.
- A write pulse coincident with reset deassertion is ignored.
- Registered state: w_ptr, r_ptr (ADDR_W bits each, wrap mod 2**ADDR_W), count (ADDR_W+1 bits), overrun. Status outputs are derived from these registers.
  - empty = (count==0).
  - full = (count==2**ADDR_W).
  - All outputs are glitch-free functions of registers; no combinational path from wr/rd to any output.
- Push, when wr=1 and full=0:
  - mem[w_ptr] <= w_data; w_ptr increments.
  - Visible on r_data the next cycle if the FIFO was empty (latency 1 clk from wr to empty=0).
- Pop, when rd=1 and empty=0:
  - r_ptr increments.
  - r_data shows the next entry the following cycle.
- rd with empty=1: ignored; no pointer or count change, no underflow flag.
- wr with full=1 and rd=0:
  - Data dropped, pointers unchanged.
  - overrun <= 1 on the same edge.
- Simultaneous wr and rd:
  - Not empty and not full: push and pop both occur; count unchanged.
  - Full: pop and push both occur; count stays at max; no overrun.
  - Empty: push only; the rd is ignored; count becomes 1.
- count update: +1 on push-only, -1 on pop-only, unchanged otherwise.
- overrun:
  - Set by a dropped write; cleared by clr_overrun.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: pointers roll from 2**ADDR_W-1 to 0 with no bubble; ordering is strictly FIFO across the wrap.
- wr is a single-cycle strobe by contract. Back-to-back wr on consecutive cycles is supported: each cycle is a separate push.

Decomposition:
- Shared package uart_pkg holds:
  - Default DBIT (8).
  - Oversampling constant SB_TICK (16).
  - Localparam DEPTH = 2**ADDR_W, computed here from ADDR_W.
- One natural sub-module, uart_fifo_ctrl:
  - Contains pointer, count, empty/full and overrun logic.
  - Emits wr_en/rd_en qualifiers and the pointers.
- The top holds the storage array and the r_data mux/zero-force.

Test Plan:
- Reset, then single wr with w_data=0x55 -> next cycle empty=0, count=1, r_data=0x55; rd -> next cycle empty=1, r_data=0x00.
- Push 16 bytes 0x00..0x0F with no reads -> full=1, count=16, overrun=0; 17th wr with 0xAA -> overrun=1, count=16; drain 16 reads -> 0x00..0x0F in order, 0xAA never appears.
- Wrap test:
  - Setup: push 10, pop 10, then push 12 bytes 0x20..0x2B.
  - Required: pointers wrap; reads return 0x20..0x2B in order; empty=1 after the 12th pop.
- Full with simultaneous wr=1 (0x77) and rd=1 -> head popped, 0x77 stored at tail, count stays 16, overrun stays 0; draining returns 0x77 last.
- Empty with simultaneous wr=1 (0x3C) and rd=1 -> count=1, r_data=0x3C next cycle; rd alone on empty -> no change.
- Overrun clearing:
  - Set overrun, then assert clr_overrun and a dropped wr in the same cycle -> overrun remains 1.
  - clr_overrun alone -> overrun=0.
  - Assert reset_n=0 mid-burst with count=5 -> count=0, empty=1 immediately.
